// File: rtl/cdc_src_clear_gate_pkg.sv
// Shared types for the CDC source-side clear gate.
// Holds the sequencing state encoding.
package cdc_src_clear_gate_pkg;

   typedef enum logic [2:0] {
      IDLE,
      QUIESCE,
      CLEAR,
      WAIT_RISE,
      WAIT_FALL,
      FOREIGN
   } state_e;

endpackage

// File: rtl/cdc_src_clear_gate_fifo.sv
// Small synchronous FIFO with flush, usage and full/empty flags.
// No bypass: a pushed word is visible at the head one cycle later.
module cdc_src_clear_gate_fifo #(
   parameter type         T     = logic,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned UW   = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          flush_i,
   input  logic          push_i,
   input  T              data_i,
   input  logic          pop_i,
   output T              data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [UW-1:0] usage_o
);

   T              mem_q [DEPTH];
   T              mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [UW-1:0] cnt_q, cnt_d;

   assign full_o  = (cnt_q == UW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign usage_o = cnt_q;
   assign data_o  = mem_q[rd_ptr_q];

   // Next pointers, count and storage; flush overrides any push or pop.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         end
         if (push_i && !pop_i) begin
            cnt_d = cnt_q + 1'b1;
         end else if (pop_i && !push_i) begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/cdc_src_clear_gate.sv
// Source-domain front end for the clearable two-phase CDC.
// Buffers traffic and sequences local/foreign clears safely.
module cdc_src_clear_gate
   import cdc_src_clear_gate_pkg::*;
#(
   parameter type         T             = logic,
   parameter int unsigned DEPTH         = 4,
   parameter bit          DROP_ON_CLEAR = 1'b1,
   parameter int unsigned PEND_TIMEOUT  = 16,
   localparam int unsigned UW           = $clog2(DEPTH + 1),
   localparam int unsigned CW           = $clog2(PEND_TIMEOUT + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_req_i,
   output logic          clear_busy_o,
   output logic          clear_err_o,
   input  T              in_data_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   output logic [UW-1:0] usage_o,
   output T              cdc_data_o,
   output logic          cdc_valid_o,
   input  logic          cdc_ready_i,
   output logic          cdc_clear_o,
   input  logic          cdc_clear_pending_i
);

   if (DEPTH < 2) begin : g_depth_chk
      $error("cdc_src_clear_gate: DEPTH must be at least 2");
   end
   if (PEND_TIMEOUT < 1) begin : g_tmo_chk
      $error("cdc_src_clear_gate: PEND_TIMEOUT must be at least 1");
   end

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          req_q, req_d;
   logic          clr_q, clr_d;
   logic          full, empty, flush;
   logic          push, pop;

   assign in_ready_o   = !full && (state_q == IDLE || !DROP_ON_CLEAR);
   assign cdc_valid_o  = !empty && (state_q == IDLE);
   assign push         = in_valid_i && in_ready_o;
   assign pop          = cdc_valid_o && cdc_ready_i;
   assign flush        = DROP_ON_CLEAR && (state_q == CLEAR);
   assign clear_busy_o = (state_q != IDLE);
   assign clear_err_o  = err_q;
   assign cdc_clear_o  = clr_q;

   cdc_src_clear_gate_fifo #(
      .T     (T),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush),
      .push_i  (push),
      .data_i  (in_data_i),
      .pop_i   (pop),
      .data_o  (cdc_data_o),
      .full_o  (full),
      .empty_o (empty),
      .usage_o (usage_o)
   );

   // Clear sequencer: next state, timeout counter, error and latched request.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      req_d   = req_q;
      unique case (state_q)
         IDLE: begin
            if (clear_req_i) begin
               state_d = QUIESCE;
            end else if (cdc_clear_pending_i) begin
               state_d = FOREIGN;
            end
         end
         QUIESCE: begin
            state_d = CLEAR;
         end
         CLEAR: begin
            cnt_d   = '0;
            state_d = WAIT_RISE;
         end
         WAIT_RISE: begin
            if (cdc_clear_pending_i) begin
               state_d = WAIT_FALL;
            end else if (cnt_q == CW'(PEND_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_FALL: begin
            if (!cdc_clear_pending_i) begin
               state_d = IDLE;
            end
         end
         FOREIGN: begin
            if (clear_req_i) begin
               req_d = 1'b1;
            end
            if (!cdc_clear_pending_i) begin
               if (req_q || clear_req_i) begin
                  req_d   = 1'b0;
                  state_d = QUIESCE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (state_d == QUIESCE && state_q != QUIESCE) begin
         err_d = 1'b0;
      end
      clr_d = (state_d == CLEAR);
   end

   // Sequencer registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         req_q   <= req_d;
         clr_q   <= clr_d;
      end
   end

endmodule

// File: tb/tb_cdc_src_clear_gate.sv
// Directed bench for cdc_src_clear_gate.
// DEPTH=4, DROP_ON_CLEAR=1, PEND_TIMEOUT=16, 8-bit payload.
module tb_cdc_src_clear_gate;

   typedef logic [7:0] byte_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear_req;
   logic       clear_busy;
   logic       clear_err;
   byte_t      in_data;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] usage;
   byte_t      cdc_data;
   logic       cdc_valid;
   logic       cdc_ready;
   logic       cdc_clear;
   logic       pending;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cdc_src_clear_gate #(
      .T             (byte_t),
      .DEPTH         (4),
      .DROP_ON_CLEAR (1'b1),
      .PEND_TIMEOUT  (16)
   ) dut (
      .clk_i               (clk),
      .rst_ni              (rst_n),
      .clear_req_i         (clear_req),
      .clear_busy_o        (clear_busy),
      .clear_err_o         (clear_err),
      .in_data_i           (in_data),
      .in_valid_i          (in_valid),
      .in_ready_o          (in_ready),
      .usage_o             (usage),
      .cdc_data_o          (cdc_data),
      .cdc_valid_o         (cdc_valid),
      .cdc_ready_i         (cdc_ready),
      .cdc_clear_o         (cdc_clear),
      .cdc_clear_pending_i (pending)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_req = 1'b0;
      in_data = '0;
      in_valid = 1'b0;
      cdc_ready = 1'b0;
      pending = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      checks++; if (usage !== 3'd0) begin errors++; $display("FAIL rst_usage got=%0d exp=0", usage); end
      checks++; if (cdc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", cdc_valid); end
      checks++; if (cdc_clear !== 1'b0) begin errors++; $display("FAIL rst_clear got=%b exp=0", cdc_clear); end
      checks++; if (clear_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", clear_err); end
      checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", clear_busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_stream();
      cdc_ready = 1'b1;
      in_valid = 1'b1;
      in_data = 8'hA1;
      #1;
      checks++; if (cdc_valid !== 1'b0) begin errors++; $display("FAIL stream_nobypass got=%b exp=0", cdc_valid); end
      tick();
      checks++; if (cdc_valid !== 1'b1 || cdc_data !== 8'hA1) begin errors++; $display("FAIL stream_a got=%b/%h exp=1/a1", cdc_valid, cdc_data); end
      in_data = 8'hB2;
      tick();
      checks++; if (cdc_data !== 8'hB2 || usage !== 3'd1) begin errors++; $display("FAIL stream_b got=%h/%0d exp=b2/1", cdc_data, usage); end
      in_data = 8'hC3;
      tick();
      checks++; if (cdc_data !== 8'hC3 || cdc_valid !== 1'b1) begin errors++; $display("FAIL stream_c got=%h/%b exp=c3/1", cdc_data, cdc_valid); end
      in_valid = 1'b0;
      tick();
      checks++; if (usage !== 3'd0 || cdc_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%0d/%b exp=0/0", usage, cdc_valid); end
   endtask

   task automatic test_full();
      byte_t exp_q [$];
      cdc_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = byte_t'(8'h10 + i);
         tick();
      end
      checks++; if (usage !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL full_flag got=%0d/%b exp=4/0", usage, in_ready); end
      in_data = 8'hEE;
      tick();
      checks++; if (usage !== 3'd4) begin errors++; $display("FAIL full_holdoff got=%0d exp=4", usage); end
      cdc_ready = 1'b1;
      tick();
      checks++; if (usage !== 3'd3 || in_ready !== 1'b1 || cdc_data !== 8'h11) begin errors++; $display("FAIL full_pop got=%0d/%b/%h exp=3/1/11", usage, in_ready, cdc_data); end
      cdc_ready = 1'b0;
      tick();
      checks++; if (usage !== 3'd4) begin errors++; $display("FAIL full_refill got=%0d exp=4", usage); end
      in_valid = 1'b0;
      cdc_ready = 1'b1;
      exp_q = '{8'h11, 8'h12, 8'h13, 8'hEE};
      for (int i = 0; i < 4; i++) begin
         checks++; if (cdc_valid !== 1'b1 || cdc_data !== exp_q[i]) begin errors++; $display("FAIL full_order%0d got=%b/%h exp=1/%h", i, cdc_valid, cdc_data, exp_q[i]); end
         tick();
      end
      checks++; if (usage !== 3'd0) begin errors++; $display("FAIL full_empty got=%0d exp=0", usage); end
   endtask

   task automatic test_local_clear();
      cdc_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 8'h21;
      tick();
      in_data = 8'h22;
      tick();
      in_valid = 1'b0;
      checks++; if (usage !== 3'd2 || cdc_valid !== 1'b1) begin errors++; $display("FAIL lclr_pre got=%0d/%b exp=2/1", usage, cdc_valid); end
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      checks++; if (cdc_valid !== 1'b0 || cdc_clear !== 1'b0 || clear_busy !== 1'b1) begin errors++; $display("FAIL lclr_quiesce got=%b/%b/%b exp=0/0/1", cdc_valid, cdc_clear, clear_busy); end
      tick();
      checks++; if (cdc_valid !== 1'b0 || cdc_clear !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL lclr_clear got=%b/%b/%b exp=0/1/0", cdc_valid, cdc_clear, in_ready); end
      tick();
      checks++; if (usage !== 3'd0 || cdc_clear !== 1'b0) begin errors++; $display("FAIL lclr_flush got=%0d/%b exp=0/0", usage, cdc_clear); end
      pending = 1'b1;
      tick();
      tick();
      checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL lclr_waitfall got=%b exp=1", clear_busy); end
      pending = 1'b0;
      tick();
      checks++; if (clear_busy !== 1'b0 || in_ready !== 1'b1 || clear_err !== 1'b0) begin errors++; $display("FAIL lclr_done got=%b/%b/%b exp=0/1/0", clear_busy, in_ready, clear_err); end
   endtask

   task automatic test_timeout();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      tick();
      checks++; if (cdc_clear !== 1'b1) begin errors++; $display("FAIL tmo_clear got=%b exp=1", cdc_clear); end
      for (int i = 0; i < 16; i++) tick();
      checks++; if (clear_busy !== 1'b1 || clear_err !== 1'b0) begin errors++; $display("FAIL tmo_early got=%b/%b exp=1/0", clear_busy, clear_err); end
      tick();
      checks++; if (clear_busy !== 1'b0 || clear_err !== 1'b1) begin errors++; $display("FAIL tmo_fire got=%b/%b exp=0/1", clear_busy, clear_err); end
      tick();
      checks++; if (clear_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got=%b exp=1", clear_err); end
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      tick();
      checks++; if (clear_err !== 1'b0 || cdc_clear !== 1'b1) begin errors++; $display("FAIL tmo_reclear got=%b/%b exp=0/1", clear_err, cdc_clear); end
      pending = 1'b1;
      tick();
      tick();
      pending = 1'b0;
      tick();
      checks++; if (clear_busy !== 1'b0 || clear_err !== 1'b0) begin errors++; $display("FAIL tmo_recover got=%b/%b exp=0/0", clear_busy, clear_err); end
   endtask

   task automatic test_foreign();
      cdc_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 8'h31;
      tick();
      in_data = 8'h32;
      tick();
      in_valid = 1'b0;
      pending = 1'b1;
      tick();
      checks++; if (cdc_valid !== 1'b0 || usage !== 3'd2 || clear_busy !== 1'b1) begin errors++; $display("FAIL fgn_enter got=%b/%0d/%b exp=0/2/1", cdc_valid, usage, clear_busy); end
      pending = 1'b0;
      tick();
      checks++; if (clear_busy !== 1'b0 || cdc_valid !== 1'b1 || cdc_data !== 8'h31) begin errors++; $display("FAIL fgn_plain got=%b/%b/%h exp=0/1/31", clear_busy, cdc_valid, cdc_data); end
      pending = 1'b1;
      tick();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      tick();
      checks++; if (cdc_valid !== 1'b0 || usage !== 3'd2 || cdc_clear !== 1'b0) begin errors++; $display("FAIL fgn_hold got=%b/%0d/%b exp=0/2/0", cdc_valid, usage, cdc_clear); end
      pending = 1'b0;
      tick();
      checks++; if (clear_busy !== 1'b1 || cdc_clear !== 1'b0 || cdc_valid !== 1'b0) begin errors++; $display("FAIL fgn_quiesce got=%b/%b/%b exp=1/0/0", clear_busy, cdc_clear, cdc_valid); end
      tick();
      checks++; if (cdc_clear !== 1'b1) begin errors++; $display("FAIL fgn_clear got=%b exp=1", cdc_clear); end
      tick();
      checks++; if (usage !== 3'd0 || clear_busy !== 1'b1) begin errors++; $display("FAIL fgn_waitrise got=%0d/%b exp=0/1", usage, clear_busy); end
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      tick();
      checks++; if (clear_busy !== 1'b0 || cdc_clear !== 1'b0 || clear_err !== 1'b0) begin errors++; $display("FAIL rmid_state got=%b/%b/%b exp=0/0/0", clear_busy, cdc_clear, clear_err); end
      checks++; if (usage !== 3'd0 || cdc_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmid_fifo got=%0d/%b/%b exp=0/0/1", usage, cdc_valid, in_ready); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (cdc_clear !== 1'b0) begin errors++; $display("FAIL rmid_noclear%0d got=%b exp=0", i, cdc_clear); end
      end
      rst_n = 1'b1;
      tick();
      checks++; if (clear_busy !== 1'b0 || cdc_clear !== 1'b0) begin errors++; $display("FAIL rmid_release got=%b/%b exp=0/0", clear_busy, cdc_clear); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_local_clear();
      test_timeout();
      test_foreign();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
